// File: rtl/simon_pkg.sv
// Shared constants, types and helpers for the SIMON64/96 iterative decryptor.
package simon_pkg;

  localparam int          SIMON64_N    = 32;
  localparam int          SIMON64_96_T = 42;
  localparam logic [31:0] SIMON_C      = 32'hFFFFFFFC;
  // z2 sequence; index 0 is the leftmost (MSB) bit.
  localparam logic [61:0] SIMON_Z2     =
    62'b10101111011100000011010010011000101000010001111110010110110011;

  typedef enum logic [1:0] {IDLE, EXPAND, ROUND, DONE} state_e;

  typedef struct packed {
    logic [SIMON64_N-1:0] x;
    logic [SIMON64_N-1:0] y;
  } blk_t;

  function automatic logic [SIMON64_N-1:0] rol(input logic [SIMON64_N-1:0] w, input int s);
    return (w << s) | (w >> (SIMON64_N - s));
  endfunction

  function automatic logic [SIMON64_N-1:0] ror(input logic [SIMON64_N-1:0] w, input int s);
    return (w >> s) | (w << (SIMON64_N - s));
  endfunction

  // Round function
  function automatic logic [SIMON64_N-1:0] f(input logic [SIMON64_N-1:0] w);
    return (rol(w, 1) & rol(w, 8)) ^ rol(w, 2);
  endfunction

  // Key schedule mixing term applied to k[i-1]
  function automatic logic [SIMON64_N-1:0] key_tmp(input logic [SIMON64_N-1:0] w);
    logic [SIMON64_N-1:0] t;
    t = ror(w, 3);
    return t ^ ror(t, 1);
  endfunction

  function automatic logic z2_bit(input logic [5:0] j);
    return SIMON_Z2[6'd61 - j];
  endfunction

endpackage

// File: rtl/simon64_key_step.sv
// Combinational SIMON64/96 key step over a 3-word window {oldest..newest}.
// Forward (dir=0): window {k[i-3],k[i-2],k[i-1]} -> k[i].
// Backward (dir=1): window {k[i-2],k[i-1],k[i]} -> k[i-3].
module simon64_key_step
  import simon_pkg::*;
(
  input  logic [2:0][SIMON64_N-1:0] i_win,
  input  logic [5:0]                i_idx,
  input  logic                      i_dir,
  output logic [SIMON64_N-1:0]      o_next
);

  logic [5:0]           w_zi;
  logic [SIMON64_N-1:0] w_z;

  // Index below 3 only happens on the final backward steps, whose result is unused.
  assign w_zi = (i_idx >= 6'd3) ? (i_idx - 6'd3) : 6'd0;
  assign w_z  = {{(SIMON64_N-1){1'b0}}, z2_bit(w_zi)};

  assign o_next = i_dir ? (i_win[2] ^ SIMON_C ^ w_z ^ key_tmp(i_win[1]))
                        : (i_win[0] ^ SIMON_C ^ w_z ^ key_tmp(i_win[2]));

endmodule

// File: rtl/simon64_96_iter_dec.sv
// Iterative SIMON64/96 decryptor, one round per clock.
// Expands the key forward to {k39,k40,k41}, then decrypts rounds 41..0 while
// running the key schedule backwards through the same 3-word window.
// Optional: define SIMON_KEY_CACHE_EN to keep the last key and its final
// window so a repeated key skips the expansion phase.
module simon64_96_iter_dec
  import simon_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_block,
  input  logic [95:0] in_key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_block
);

  localparam logic [5:0] LAST_IDX = 6'(SIMON64_96_T - 1);

  state_e                    r_state, w_state_nxt;
  logic [5:0]                r_idx;
  logic [2:0][SIMON64_N-1:0] r_win;
  blk_t                      r_blk, w_blk_nxt;
  logic [63:0]               r_out;
  logic [SIMON64_N-1:0]      w_kstep;
  logic [2:0][SIMON64_N-1:0] w_win_fwd, w_win_bwd, w_cache_win;
  logic                      w_hit;

  simon64_key_step u_key_step (
    .i_win  (r_win),
    .i_idx  (r_idx),
    .i_dir  (r_state == ROUND),
    .o_next (w_kstep)
  );

  assign w_win_fwd = {w_kstep, r_win[2], r_win[1]};
  assign w_win_bwd = {r_win[1], r_win[0], w_kstep};
  assign w_blk_nxt = {r_blk.y, r_blk.x ^ f(r_blk.y) ^ r_win[2]};

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign out_block = r_out;

`ifdef SIMON_KEY_CACHE_EN
  logic                      r_cache_vld;
  logic [95:0]               r_cache_key;
  logic [2:0][SIMON64_N-1:0] r_cache_win;

  assign w_hit       = r_cache_vld && (in_key == r_cache_key);
  assign w_cache_win = r_cache_win;

  // Cache tracks the key of the job being expanded; valid only once its window is complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cache_vld <= 1'b0;
      r_cache_key <= '0;
      r_cache_win <= '0;
    end else begin
      if (r_state == IDLE && in_valid && !w_hit) begin
        r_cache_key <= in_key;
        r_cache_vld <= 1'b0;
      end
      if (r_state == EXPAND && r_idx == LAST_IDX) begin
        r_cache_win <= w_win_fwd;
        r_cache_vld <= 1'b1;
      end
    end
  end
`else
  assign w_hit       = 1'b0;
  assign w_cache_win = '0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = w_hit ? ROUND : EXPAND;
      EXPAND:  if (r_idx == LAST_IDX) w_state_nxt = ROUND;
      ROUND:   if (r_idx == 6'd0) w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: latch job, step key window, run rounds, capture result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_win <= '0;
      r_blk <= '0;
      r_out <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_blk <= in_block;
          if (w_hit) begin
            r_win <= w_cache_win;
            r_idx <= LAST_IDX;
          end else begin
            r_win <= in_key;
            r_idx <= 6'd3;
          end
        end
        EXPAND: begin
          r_win <= w_win_fwd;
          if (r_idx != LAST_IDX) r_idx <= r_idx + 6'd1;
        end
        ROUND: begin
          r_blk <= w_blk_nxt;
          r_win <= w_win_bwd;
          if (r_idx != 6'd0) r_idx <= r_idx - 6'd1;
          else               r_out <= w_blk_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simon64_96_iter_dec.sv
// Self-checking bench for simon64_96_iter_dec against a full-key-table SIMON64/96 model.
module tb_simon64_96_iter_dec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [63:0] in_block = '0;
  logic [95:0] in_key = '0;
  logic        in_ready, out_valid;
  logic [63:0] out_block;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned acc = 0;
  bit          cache_vld = 1'b0;
  logic [95:0] cache_key = '0;

`ifdef SIMON_KEY_CACHE_EN
  localparam bit CACHE_ON = 1'b1;
`else
  localparam bit CACHE_ON = 1'b0;
`endif

  localparam logic [95:0] KAT_KEY = 96'h131211100b0a090803020100;
  localparam logic [63:0] KAT_CT  = 64'h5ca2e27f111a8fc8;
  localparam logic [63:0] KAT_PT  = 64'h6f7220676e696c63;

  simon64_96_iter_dec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] rl(input logic [31:0] w, input int s);
    logic [63:0] d;
    d = {w, w};
    return d[63-s -: 32];
  endfunction

  function automatic logic [31:0] rr(input logic [31:0] w, input int s);
    return rl(w, 32 - s);
  endfunction

  function automatic logic [63:0] ref_enc(input logic [95:0] key, input logic [63:0] pt);
    logic [31:0] k [0:41];
    logic [61:0] z;
    logic [31:0] x, y, t;
    z = 62'b10101111011100000011010010011000101000010001111110010110110011;
    for (int i = 0; i < 3; i++) k[i] = key[32*i +: 32];
    for (int i = 3; i < 42; i++) begin
      t    = rr(k[i-1], 3);
      t    = t ^ rr(t, 1);
      k[i] = ~k[i-3] ^ t ^ 32'd3 ^ 32'(z[61-(i-3)]);
    end
    x = pt[63:32];
    y = pt[31:0];
    for (int i = 0; i < 42; i++) begin
      t = x;
      x = y ^ (rl(x, 1) & rl(x, 8)) ^ rl(x, 2) ^ k[i];
      y = t;
    end
    return {x, y};
  endfunction

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic start_job(input logic [95:0] key, input logic [63:0] blk, output int exp_lat);
    int guard;
    guard   = 0;
    exp_lat = (CACHE_ON && cache_vld && key == cache_key) ? 42 : 81;
    cache_vld = CACHE_ON;
    cache_key = key;
    in_valid = 1'b1;
    in_block = blk;
    in_key   = key;
    while (in_ready !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    acc      = cyc;
    in_valid = 1'b0;
    in_block = {$urandom, $urandom};
    in_key   = {$urandom, $urandom, $urandom};
  endtask

  task automatic wait_done(output logic [63:0] res, output int lat);
    while (out_valid !== 1'b1 && (cyc - acc) < 300) @(negedge clk);
    lat = int'(cyc - acc);
    res = out_block;
  endtask

  task automatic finish_job(input bit keep);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = keep;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_block !== 64'd0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b blk=%h exp rdy=1 vld=0 blk=0",
               in_ready, out_valid, out_block);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got rdy=%b vld=%b exp rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_kat;
    int e, l;
    logic [63:0] r;
    start_job(KAT_KEY, KAT_CT, e);
    wait_done(r, l);
    checks++;
    if (r !== KAT_PT) begin
      errors++;
      $display("FAIL kat_result got %h exp %h", r, KAT_PT);
    end
    checks++;
    if (l !== e) begin
      errors++;
      $display("FAIL kat_latency got %0d exp %0d", l, e);
    end
    finish_job(1'b0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL kat_handshake got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure;
    int e, l;
    logic [63:0] r;
    start_job(KAT_KEY, KAT_CT, e);
    wait_done(r, l);
    checks++;
    if (l !== e) begin
      errors++;
      $display("FAIL bp_latency got %0d exp %0d", l, e);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_block !== KAT_PT) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got vld=%b rdy=%b blk=%h exp vld=1 rdy=0 blk=%h",
                 i, out_valid, in_ready, out_block, KAT_PT);
      end
      @(negedge clk);
    end
    finish_job(1'b0);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release got vld=%b rdy=%b exp vld=0 rdy=1", out_valid, in_ready);
    end
  endtask

  task automatic test_busy_drop;
    int e, l;
    logic [63:0] r;
    start_job(KAT_KEY, KAT_CT, e);
    while ((cyc - acc) < 10) @(negedge clk);
    in_valid = 1'b1;
    in_block = ~KAT_CT;
    in_key   = ~KAT_KEY;
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(r, l);
    checks++;
    if (r !== KAT_PT) begin
      errors++;
      $display("FAIL busy_result got %h exp %h", r, KAT_PT);
    end
    checks++;
    if (l !== e) begin
      errors++;
      $display("FAIL busy_latency got %0d exp %0d", l, e);
    end
    finish_job(1'b0);
  endtask

  task automatic test_reset_mid;
    int e, l;
    logic [63:0] r, pt, ct;
    logic [95:0] key;
    key = KAT_KEY ^ 96'h1;
    pt  = {$urandom, $urandom};
    ct  = ref_enc(key, pt);
    start_job(key, ct, e);
    while ((cyc - acc) < 60) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_block !== 64'd0) begin
      errors++;
      $display("FAIL midreset_state got vld=%b rdy=%b blk=%h exp vld=0 rdy=1 blk=0",
               out_valid, in_ready, out_block);
    end
    cache_vld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_job(key, ct, e);
    wait_done(r, l);
    checks++;
    if (r !== pt || l !== e) begin
      errors++;
      $display("FAIL midreset_fresh got %h lat %0d exp %h lat %0d", r, l, pt, e);
    end
    finish_job(1'b0);
  endtask

  task automatic test_cache;
    int e, l;
    logic [63:0] r, pt, ct;
    logic [95:0] key;
    key = {$urandom, $urandom, $urandom};
    for (int j = 0; j < 3; j++) begin
      if (j == 2) key = key ^ {64'd0, 32'($urandom) | 32'd1};
      pt = {$urandom, $urandom};
      ct = ref_enc(key, pt);
      start_job(key, ct, e);
      wait_done(r, l);
      checks++;
      if (r !== pt || l !== e) begin
        errors++;
        $display("FAIL cache_job%0d got %h lat %0d exp %h lat %0d", j, r, l, pt, e);
      end
      finish_job(1'b0);
    end
  endtask

  task automatic test_back_to_back;
    int e, l;
    logic [63:0] r, pt, ct;
    logic [95:0] key;
    key = {$urandom, $urandom, $urandom};
    for (int j = 0; j < 200; j++) begin
      if (j % 4 != 3) key = {$urandom, $urandom, $urandom};
      pt = {$urandom, $urandom};
      ct = ref_enc(key, pt);
      start_job(key, ct, e);
      wait_done(r, l);
      checks++;
      if (r !== pt || l !== e) begin
        errors++;
        $display("FAIL b2b_job%0d key %h got %h lat %0d exp %h lat %0d", j, key, r, l, pt, e);
      end
      finish_job(1'($urandom_range(0, 1)));
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset;
    test_kat;
    test_backpressure;
    test_busy_drop;
    test_reset_mid;
    test_cache;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
